// File: rtl/bk_sector_server.sv
// Sector responder for the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* block protocol.
// Moves one 256-word sector per request between the requester's buffer RAM
// and a word-wide backing store, and announces a mounted image on request.
module bk_sector_server #(
   parameter int LBA_BITS    = 8,
   parameter int IMG_SECTORS = 128,
   parameter int ACK_DELAY   = 4
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                mount,
   input  logic                readonly_in,
   input  logic [31:0]         sd_lba,
   input  logic                sd_rd,
   input  logic                sd_wr,
   output logic                sd_ack,
   output logic [7:0]          sd_buff_addr,
   output logic [15:0]         sd_buff_dout,
   input  logic [15:0]         sd_buff_din,
   output logic                sd_buff_wr,
   output logic                img_mounted,
   output logic                img_readonly,
   output logic [63:0]         img_size,
   output logic [LBA_BITS+7:0] st_addr,
   output logic                st_rd,
   output logic                st_wr,
   output logic [15:0]         st_dout,
   input  logic [15:0]         st_din,
   input  logic                st_ready,
   output logic                err_oor
);

   // state    | meaning
   // IDLE     | waiting for sd_rd/sd_wr; mount announcements served here
   // DELAY    | request accepted, counting down to sd_ack rise
   // RD_REQ   | fetch word from store (skipped when out of range)
   // RD_PUT   | write fetched word into requester buffer
   // WR_ADDR  | present buffer address to requester RAM
   // WR_WAIT  | requester RAM latency; capture its data at the end
   // WR_STORE | push captured word into store (skipped when out of range)
   // DONE     | one sd_ack-low cycle before the next sector
   typedef enum logic [2:0] {
      S_IDLE, S_DELAY, S_RD_REQ, S_RD_PUT, S_WR_ADDR, S_WR_WAIT, S_WR_STORE, S_DONE
   } state_t;

   localparam logic [3:0]  ACK_CNT   = 4'(ACK_DELAY);
   localparam logic [63:0] IMG_BYTES = 64'(IMG_SECTORS) * 64'd512;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [7:0]          word_q, word_d;
   logic [LBA_BITS-1:0] lba_q, lba_d;
   logic                is_rd_q, is_rd_d;
   logic                oor_q, oor_d;
   logic [15:0]         data_q, data_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                mnt_pend_q, mnt_pend_d;
   logic                mnt_ro_q, mnt_ro_d;
   logic                img_mounted_q, img_mounted_d;
   logic                img_ro_q, img_ro_d;
   logic [63:0]         img_size_q, img_size_d;

   logic accept;
   logic req_oor;

   // A request is only looked at in IDLE; the range check uses the full 32-bit LBA.
   assign accept  = (state_q == S_IDLE) && (sd_rd || sd_wr) && !reset;
   assign req_oor = (sd_lba >= 32'(IMG_SECTORS)) || (!sd_rd && img_ro_q);

   // State and datapath registers; reset drops any transfer and pending mount at once.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         word_q        <= '0;
         lba_q         <= '0;
         is_rd_q       <= 1'b0;
         oor_q         <= 1'b0;
         data_q        <= '0;
         wdata_q       <= '0;
         mnt_pend_q    <= 1'b0;
         mnt_ro_q      <= 1'b0;
         img_mounted_q <= 1'b0;
         img_ro_q      <= 1'b0;
         img_size_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         word_q        <= word_d;
         lba_q         <= lba_d;
         is_rd_q       <= is_rd_d;
         oor_q         <= oor_d;
         data_q        <= data_d;
         wdata_q       <= wdata_d;
         mnt_pend_q    <= mnt_pend_d;
         mnt_ro_q      <= mnt_ro_d;
         img_mounted_q <= img_mounted_d;
         img_ro_q      <= img_ro_d;
         img_size_q    <= img_size_d;
      end
   end

   // Next-state, word sequencing and mount bookkeeping.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      word_d        = word_q;
      lba_d         = lba_q;
      is_rd_d       = is_rd_q;
      oor_d         = oor_q;
      data_d        = data_q;
      wdata_d       = wdata_q;
      mnt_pend_d    = mnt_pend_q;
      mnt_ro_d      = mnt_ro_q;
      img_mounted_d = 1'b0;
      img_ro_d      = img_ro_q;
      img_size_d    = img_size_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_DELAY;
               cnt_d   = ACK_CNT;
               word_d  = '0;
               lba_d   = sd_lba[LBA_BITS-1:0];
               is_rd_d = sd_rd;
               oor_d   = req_oor;
            end
         end
         S_DELAY: begin
            if (cnt_q <= 4'd1) begin
               state_d = is_rd_q ? S_RD_REQ : S_WR_ADDR;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RD_REQ: begin
            if (oor_q) begin
               data_d  = '0;
               state_d = S_RD_PUT;
            end else if (st_ready) begin
               data_d  = st_din;
               state_d = S_RD_PUT;
            end
         end
         S_RD_PUT: begin
            if (word_q == 8'hFF) begin
               word_d  = '0;
               state_d = S_DONE;
            end else begin
               word_d  = word_q + 8'd1;
               state_d = S_RD_REQ;
            end
         end
         S_WR_ADDR: state_d = S_WR_WAIT;
         S_WR_WAIT: begin
            wdata_d = sd_buff_din;
            state_d = S_WR_STORE;
         end
         S_WR_STORE: begin
            if (oor_q || st_ready) begin
               if (word_q == 8'hFF) begin
                  word_d  = '0;
                  state_d = S_DONE;
               end else begin
                  word_d  = word_q + 8'd1;
                  state_d = S_WR_ADDR;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // An announcement never shares a cycle with a request accept.
      if ((state_q == S_IDLE) && !accept && mnt_pend_q) begin
         img_mounted_d = 1'b1;
         img_ro_d      = mnt_ro_q;
         img_size_d    = IMG_BYTES;
         mnt_pend_d    = 1'b0;
      end
      if (mount) begin
         mnt_pend_d = 1'b1;
         mnt_ro_d   = readonly_in;
      end
   end

   // Protocol strobes decoded from the state; store access suppressed when out of range.
   always_comb begin
      sd_ack     = (state_q == S_RD_REQ) || (state_q == S_RD_PUT) || (state_q == S_WR_ADDR) ||
                   (state_q == S_WR_WAIT) || (state_q == S_WR_STORE);
      sd_buff_wr = (state_q == S_RD_PUT);
      st_rd      = (state_q == S_RD_REQ) && !oor_q;
      st_wr      = (state_q == S_WR_STORE) && !oor_q;
      err_oor    = accept && req_oor;
   end

   assign sd_buff_addr = word_q;
   assign sd_buff_dout = data_q;
   assign st_addr      = {lba_q, word_q};
   assign st_dout      = wdata_q;
   assign img_mounted  = img_mounted_q;
   assign img_readonly = img_ro_q;
   assign img_size     = img_size_q;

endmodule
